// File: rtl/uart_access_arbiter_pkg.sv
// Shared types and constants for the UART access arbiter.
package uart_access_arbiter_pkg;

  // Request bit 7 selects release (1) or acquire (0).
  localparam int unsigned ARB_RELEASE_BIT = 7;
  // Grant-queue bit 7 marks a timeout revoke (1) versus a grant (0).
  localparam int unsigned ARB_REVOKE_BIT  = 7;
  localparam int unsigned ARB_ID_W        = 7;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_OWNED,
    ARB_REVOKE
  } uart_arb_state_e;

  // Build a grant-queue entry from a revoke flag and an access ID.
  function automatic logic [7:0] arb_entry(input logic revoke, input logic [ARB_ID_W-1:0] id);
    logic [7:0] e;
    e = {1'b0, id};
    e[ARB_REVOKE_BIT] = revoke;
    return e;
  endfunction

endpackage

// File: rtl/uart_access_arbiter_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags and an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle; a pop on empty is
// ignored. The head reads as zero when the FIFO is empty.
module uart_access_arbiter_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

  // Occupancy follows the net effect of push and pop this cycle.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and count registers; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_access_arbiter.sv
// Grants exclusive UART ownership to one software access ID at a time. Acquire requests queue
// in arrival order; grants and timeout revokes are posted to a queue that software reads.
module uart_access_arbiter
  import uart_access_arbiter_pkg::*;
#(
  parameter int unsigned REQ_DEPTH      = 4,
  parameter int unsigned GNT_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic [7:0] req_id_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  output logic [7:0] gnt_id_o,
  output logic       gnt_valid_o,
  input  logic       gnt_ready_i,
  input  logic       activity_i,
  output logic       owner_valid_o,
  output logic [6:0] owner_id_o,
  output logic       timeout_o
);

  localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  uart_arb_state_e      state_q, state_d;
  logic [ARB_ID_W-1:0]  cur_id_q, cur_id_d;
  logic                 owner_valid_q, owner_valid_d;
  logic [ARB_ID_W-1:0]  owner_id_q, owner_id_d;
  logic [31:0]          cnt_q, cnt_d;

  logic                 acq_push, acq_pop, acq_full, acq_empty;
  logic [ARB_ID_W-1:0]  acq_head;
  logic [$clog2(REQ_DEPTH+1)-1:0] acq_count;

  logic                 gnt_push, gnt_full, gnt_empty;
  logic [7:0]           gnt_wdata;
  logic [$clog2(GNT_DEPTH+1)-1:0] gnt_count;

  logic                 req_fire, is_release, owner_hit;
  logic                 owner_reacq, owner_rel;
  logic [ARB_ID_W-1:0]  req_id;
  logic                 unused_counts;

  // Request decode. Ownership only exists in ARB_OWNED, so owner_hit implies that state.
  assign req_fire    = req_valid_i && req_ready_o;
  assign is_release  = req_id_i[ARB_RELEASE_BIT];
  assign req_id      = req_id_i[ARB_ID_W-1:0];
  assign owner_hit   = owner_valid_q && (req_id == owner_id_q);
  assign owner_reacq = req_fire && !is_release && owner_hit;
  assign owner_rel   = req_fire && is_release && owner_hit;
  // Re-acquires by the current owner only refresh its timer and are never queued.
  assign acq_push    = req_fire && !is_release && !owner_hit;

  assign req_ready_o   = !acq_full;
  assign gnt_valid_o   = !gnt_empty;
  assign owner_valid_o = owner_valid_q;
  assign owner_id_o    = owner_id_q;
  assign unused_counts = ^{acq_count, gnt_count};

  uart_access_arbiter_fifo #(
    .WIDTH (ARB_ID_W),
    .DEPTH (REQ_DEPTH)
  ) u_acq_fifo (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .push_i  (acq_push),
    .data_i  (req_id),
    .pop_i   (acq_pop),
    .data_o  (acq_head),
    .full_o  (acq_full),
    .empty_o (acq_empty),
    .count_o (acq_count)
  );

  uart_access_arbiter_fifo #(
    .WIDTH (8),
    .DEPTH (GNT_DEPTH)
  ) u_gnt_fifo (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .push_i  (gnt_push),
    .data_i  (gnt_wdata),
    .pop_i   (gnt_ready_i),
    .data_o  (gnt_id_o),
    .full_o  (gnt_full),
    .empty_o (gnt_empty),
    .count_o (gnt_count)
  );

  // Ownership FSM: next state, owner registers, inactivity counter and queue strobes.
  always_comb begin
    state_d       = state_q;
    cur_id_d      = cur_id_q;
    owner_valid_d = owner_valid_q;
    owner_id_d    = owner_id_q;
    cnt_d         = cnt_q;
    acq_pop       = 1'b0;
    gnt_push      = 1'b0;
    gnt_wdata     = '0;
    timeout_o     = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (!acq_empty) begin
          acq_pop  = 1'b1;
          cur_id_d = acq_head;
          state_d  = ARB_GRANT;
        end
      end

      // Ownership is only taken once the grant entry has room to be posted.
      ARB_GRANT: begin
        if (!gnt_full) begin
          gnt_push      = 1'b1;
          gnt_wdata     = arb_entry(1'b0, cur_id_q);
          owner_valid_d = 1'b1;
          owner_id_d    = cur_id_q;
          cnt_d         = '0;
          state_d       = ARB_OWNED;
        end
      end

      // Release beats timeout, and activity or a re-acquire beats timeout.
      ARB_OWNED: begin
        if (owner_rel) begin
          owner_valid_d = 1'b0;
          owner_id_d    = '0;
          state_d       = ARB_IDLE;
        end else if (activity_i || owner_reacq) begin
          cnt_d = '0;
        end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
          owner_valid_d = 1'b0;
          owner_id_d    = '0;
          state_d       = ARB_REVOKE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ARB_REVOKE: begin
        if (!gnt_full) begin
          gnt_push  = 1'b1;
          gnt_wdata = arb_entry(1'b1, cur_id_q);
          timeout_o = 1'b1;
          state_d   = ARB_IDLE;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  // State and owner registers; reset discards ownership without posting a revoke.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q       <= ARB_IDLE;
      cur_id_q      <= '0;
      owner_valid_q <= 1'b0;
      owner_id_q    <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cur_id_q      <= cur_id_d;
      owner_valid_q <= owner_valid_d;
      owner_id_q    <= owner_id_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_access_arbiter.sv
// Self-checking bench for uart_access_arbiter: directed vector table, hand-written corner-case
// sequences, then randomized traffic against a queue-based reference model.
module tb_uart_access_arbiter;

  localparam int REQ_DEPTH = 4;
  localparam int GNT_DEPTH = 4;
  localparam int TO        = 16;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [7:0] req_id = '0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] gnt_id;
  logic       gnt_valid;
  logic       gnt_ready = 1'b0;
  logic       activity = 1'b0;
  logic       owner_valid;
  logic [6:0] owner_id;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_access_arbiter #(
    .REQ_DEPTH      (REQ_DEPTH),
    .GNT_DEPTH      (GNT_DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i         (clk),
    .arst_ni       (arst_n),
    .req_id_i      (req_id),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .gnt_id_o      (gnt_id),
    .gnt_valid_o   (gnt_valid),
    .gnt_ready_i   (gnt_ready),
    .activity_i    (activity),
    .owner_valid_o (owner_valid),
    .owner_id_o    (owner_id),
    .timeout_o     (timeout)
  );

  // Output vector layout: {ready, gnt_valid, gnt_id[7:0], owner_valid, owner_id[6:0], timeout}
  function automatic logic [18:0] pk(input logic r, input logic gv, input logic [7:0] gid,
                                     input logic ov, input logic [6:0] oid, input logic to);
    return {r, gv, gid, ov, oid, to};
  endfunction

  function automatic logic [18:0] outs();
    return {req_ready, gnt_valid, gnt_id, owner_valid, owner_id, timeout};
  endfunction

  task automatic chk(input string name, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got rdy=%b gv=%b gid=%h ov=%b oid=%h to=%b, want rdy=%b gv=%b gid=%h ov=%b oid=%h to=%b",
               name, got[18], got[17], got[16:9], got[8], got[7:1], got[0],
               exp[18], exp[17], exp[16:9], exp[8], exp[7:1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs, sample outputs at the falling edge, return after the rising edge.
  task automatic step(input logic rv, input logic [7:0] id, input logic gr, input logic act,
                      output logic [18:0] o);
    req_valid = rv;
    req_id    = id;
    gnt_ready = gr;
    activity  = act;
    @(negedge clk);
    o = outs();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] popped[$];

  // Idle (optionally popping grants) until the given ID owns the UART, within a cycle budget.
  task automatic wait_owner(input logic [6:0] id, input logic gr, input int budget,
                            input string name);
    logic [18:0] o;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1'b0, 8'h00, gr, 1'b0, o);
      if (gr && o[17]) popped.push_back(o[16:9]);
      if (o[8] && o[7:1] == id) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: owner %h not seen within %0d cycles", name, id, budget);
    end
  endtask

  // ---------------- reference model (queues + ownership bookkeeping) ----------------
  logic [6:0]  m_acq[$];
  logic [7:0]  m_gnt[$];
  bit          m_own, m_pend, m_rev;
  logic [6:0]  m_oid, m_pid, m_rid;
  int unsigned m_cnt;

  function automatic void m_reset();
    m_acq.delete();
    m_gnt.delete();
    m_own = 0; m_pend = 0; m_rev = 0;
    m_oid = '0; m_pid = '0; m_rid = '0; m_cnt = 0;
  endfunction

  function automatic logic [18:0] m_exp();
    logic [7:0] gid;
    gid = (m_gnt.size() > 0) ? m_gnt[0] : 8'h00;
    return pk(m_acq.size() < REQ_DEPTH, m_gnt.size() > 0, gid, m_own,
              m_own ? m_oid : 7'h00, m_rev && (m_gnt.size() < GNT_DEPTH));
  endfunction

  function automatic void m_step(input logic rv, input logic [7:0] id, input logic gr,
                                 input logic act);
    int  acq_n, gnt_n;
    bit  fire, rel, hit;
    acq_n = m_acq.size();
    gnt_n = m_gnt.size();
    fire  = rv && (acq_n < REQ_DEPTH);
    rel   = id[7];
    hit   = m_own && (id[6:0] == m_oid);
    if (gr && gnt_n > 0) void'(m_gnt.pop_front());
    if (m_own) begin
      if (fire && rel && hit) m_own = 0;
      else if (act || (fire && !rel && hit)) m_cnt = 0;
      else if (m_cnt == TO - 1) begin
        m_own = 0; m_rev = 1; m_rid = m_oid;
      end else if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end else if (m_rev) begin
      if (gnt_n < GNT_DEPTH) begin m_gnt.push_back({1'b1, m_rid}); m_rev = 0; end
    end else if (m_pend) begin
      if (gnt_n < GNT_DEPTH) begin
        m_gnt.push_back({1'b0, m_pid});
        m_own = 1; m_oid = m_pid; m_cnt = 0; m_pend = 0;
      end
    end else if (acq_n > 0) begin
      m_pid = m_acq.pop_front();
      m_pend = 1;
    end
    if (fire && !rel && !hit) m_acq.push_back(id[6:0]);
  endfunction

  typedef struct {
    logic        rv;
    logic [7:0]  id;
    logic        gr;
    logic        act;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [18:0] o;
    logic [7:0]  exp_list[$];

    // Acquire 0x05 from idle, pop its grant; owner 0x05 queues 0x03 then releases.
    tbl.push_back(vec_t'{1'b1, 8'h05, 1'b0, 1'b0, pk(1, 0, 8'h00, 0, 7'h00, 0)});
    tbl.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, pk(1, 0, 8'h00, 0, 7'h00, 0)});
    tbl.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, pk(1, 0, 8'h00, 0, 7'h00, 0)});
    tbl.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, pk(1, 1, 8'h05, 1, 7'h05, 0)});
    tbl.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, pk(1, 1, 8'h05, 1, 7'h05, 0)});
    tbl.push_back(vec_t'{1'b1, 8'h03, 1'b0, 1'b0, pk(1, 0, 8'h00, 1, 7'h05, 0)});
    tbl.push_back(vec_t'{1'b1, 8'h85, 1'b0, 1'b0, pk(1, 0, 8'h00, 1, 7'h05, 0)});
    tbl.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, pk(1, 0, 8'h00, 0, 7'h00, 0)});
    tbl.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, pk(1, 0, 8'h00, 0, 7'h00, 0)});
    tbl.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, pk(1, 1, 8'h03, 1, 7'h03, 0)});
    tbl.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, pk(1, 1, 8'h03, 1, 7'h03, 0)});
    tbl.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, pk(1, 0, 8'h00, 1, 7'h03, 0)});

    // Reset state, during and after reset.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", outs(), pk(1, 0, 8'h00, 0, 7'h00, 0));
    arst_n = 1'b1;
    @(negedge clk);
    chk("reset_release", outs(), pk(1, 0, 8'h00, 0, 7'h00, 0));
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step(tbl[i].rv, tbl[i].id, tbl[i].gr, tbl[i].act, o);
      chk($sformatf("vec%0d", i), o, tbl[i].exp);
    end

    // Owner 0x03 has been owned 3 cycles; 13 more idle cycles reach the last counted cycle.
    for (int i = 0; i < 13; i++) step(1'b0, 8'h00, 1'b0, 1'b0, o);
    chk("pre_timeout", o, pk(1, 0, 8'h00, 1, 7'h03, 0));
    step(1'b0, 8'h00, 1'b0, 1'b0, o);
    chk("timeout_pulse", o, pk(1, 0, 8'h00, 0, 7'h00, 1));
    step(1'b0, 8'h00, 1'b1, 1'b0, o);
    chk("revoke_entry", o, pk(1, 1, 8'h83, 0, 7'h00, 0));

    // Periodic activity keeps the owner alive for 100 cycles.
    step(1'b1, 8'h11, 1'b0, 1'b0, o);
    wait_owner(7'h11, 1'b1, 10, "own_11");
    begin
      bit bad;
      bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
        step(1'b0, 8'h00, 1'b1, (i % 10) == 9, o);
        if (o[0] || !o[8] || o[7:1] != 7'h11) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL keepalive: owner 11 lost or revoked, got 1 want 0");
      end
    end

    // Fill the acquire queue behind owner 0x11.
    popped.delete();
    step(1'b1, 8'h01, 1'b1, 1'b1, o);
    step(1'b1, 8'h02, 1'b1, 1'b1, o);
    step(1'b1, 8'h03, 1'b1, 1'b1, o);
    step(1'b1, 8'h04, 1'b1, 1'b1, o);
    chk("fourth_accepted", o, pk(1, 0, 8'h00, 1, 7'h11, 0));
    step(1'b1, 8'h05, 1'b1, 1'b1, o);
    chk("ready_drop", o, pk(0, 0, 8'h00, 1, 7'h11, 0));
    step(1'b1, 8'h05, 1'b1, 1'b1, o);
    chk("fifth_held", o, pk(0, 0, 8'h00, 1, 7'h11, 0));
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        step(1'b0, 8'h00, 1'b1, 1'b0, o);
        if (o[17]) popped.push_back(o[16:9]);
        if (o[0]) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL timeout_11: timeout pulse got 0 want 1");
      end
    end
    for (int k = 1; k <= 4; k++) begin
      wait_owner(7'(k), 1'b1, 10, $sformatf("fifo_owner_%0d", k));
      step(1'b1, 8'h80 | 8'(k), 1'b1, 1'b0, o);
      if (o[17]) popped.push_back(o[16:9]);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, o);
      if (o[17]) popped.push_back(o[16:9]);
    end
    exp_list = '{8'h91, 8'h01, 8'h02, 8'h03, 8'h04};
    checks++;
    if (popped.size() != exp_list.size()) begin
      errors++;
      $display("FAIL grant_count: got %0d entries want %0d", popped.size(), exp_list.size());
    end
    for (int i = 0; i < exp_list.size() && i < popped.size(); i++)
      chk($sformatf("grant_order%0d", i), {11'h0, popped[i]}, {11'h0, exp_list[i]});

    // Leave four grant entries unread, then queue a fifth acquire.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'h21 + 8'(k), 1'b0, 1'b0, o);
      wait_owner(7'h21 + 7'(k), 1'b0, 10, $sformatf("fill_%0d", k));
      step(1'b1, 8'hA1 + 8'(k), 1'b0, 1'b0, o);
    end
    step(1'b1, 8'h25, 1'b0, 1'b0, o);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, o);
    chk("gnt_full_stall", o, pk(1, 1, 8'h21, 0, 7'h00, 0));
    step(1'b0, 8'h00, 1'b1, 1'b0, o);
    chk("single_pop", o, pk(1, 1, 8'h21, 0, 7'h00, 0));
    step(1'b0, 8'h00, 1'b0, 1'b0, o);
    chk("grant_push_cycle", o, pk(1, 1, 8'h22, 0, 7'h00, 0));
    step(1'b0, 8'h00, 1'b0, 1'b0, o);
    chk("grant_after_pop", o, pk(1, 1, 8'h22, 1, 7'h25, 0));
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, o);
      chk($sformatf("drain%0d", k), o, pk(1, 1, 8'h22 + 8'(k), 1, 7'h25, 0));
    end

    // Release lands on the same cycle the timeout would fire.
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0, o);
    step(1'b1, 8'hA5, 1'b0, 1'b0, o);
    chk("pre_release", o, pk(1, 0, 8'h00, 1, 7'h25, 0));
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, o);
      chk($sformatf("no_revoke%0d", i), o, pk(1, 0, 8'h00, 0, 7'h00, 0));
    end

    // Reset while owned with a non-empty queue and an unread grant.
    step(1'b1, 8'h31, 1'b0, 1'b0, o);
    wait_owner(7'h31, 1'b0, 10, "own_31");
    step(1'b1, 8'h32, 1'b0, 1'b0, o);
    step(1'b1, 8'h33, 1'b0, 1'b0, o);
    chk("pre_reset_owned", outs(), pk(1, 1, 8'h31, 1, 7'h31, 0));
    arst_n = 1'b0;
    #2;
    chk("reset_mid_async", outs(), pk(1, 0, 8'h00, 0, 7'h00, 0));
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, o);
    chk("reset_discard", o, pk(1, 0, 8'h00, 0, 7'h00, 0));

    // Randomized traffic against the reference model.
    arst_n = 1'b0;
    req_valid = 1'b0;
    gnt_ready = 1'b0;
    activity = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    m_reset();
    for (int i = 0; i < 2000; i++) begin
      logic       rv, gr, act;
      logic [7:0] id;
      logic [18:0] e;
      rv  = ($urandom % 3) == 0;
      id  = {($urandom % 3) == 0, 7'($urandom_range(1, 4))};
      gr  = ($urandom % 5) == 0;
      act = ($urandom % 12) == 0;
      e   = m_exp();
      step(rv, id, gr, act, o);
      chk($sformatf("rand%0d", i), o, e);
      m_step(rv, id, gr, act);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
